call_register_bank: RTL and testbench

- Parametrised, clocked successor to the per-floor call latch. Stores car and hall (up/down) calls for N_FLOORS floors in one block.
- Registers a call on the rising edge of each button. Clears calls when the car services a floor.
- Gives the elevator controller direction-decision flags (call above, below or here) and a pending-call count.
- Sits between the button inputs and the elevator controller FSM.

---
 rtl/call_register_bank_pkg.sv | 22 ++
 rtl/call_register_bank_call_channel.sv | 53 +++++
 rtl/call_register_bank.sv | 122 ++++++++++++
 tb/tb_call_register_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/call_register_bank_pkg.sv
// Shared elevator definitions used by the call register bank and the
// elevator controller.
//   - Channel indices: CH_CAR, CH_UP, CH_DN.
//   - N_CH: number of call channels.
//   - floor_w: floor-index width for a given floor count.
//   - count_w: width of a count of every call bit in the building.
package call_register_bank_pkg;

  localparam int N_CH   = 3;
  localparam int CH_CAR = 0;
  localparam int CH_UP  = 1;
  localparam int CH_DN  = 2;

  function automatic int floor_w(input int n_floors);
    return $clog2(n_floors);
  endfunction

  function automatic int count_w(input int n_floors);
    return $clog2(N_CH * n_floors + 1);
  endfunction

endpackage

// File: rtl/call_register_bank_call_channel.sv
// One call channel (car, hall-up or hall-down) for every floor.
// Each bit is a clocked SR cell:
//   - It is set on the rising edge of its button.
//   - It is cleared by service or by the floor going out of service.
//   - Clear wins over set.
// Ports:
//   clk, srst   : clock and synchronous active-high reset
//   btn         : level button inputs, bit i = floor i
//   floor_en    : 1 = floor in service; 0 = ignore presses and drop calls
//   clr         : per-floor clear request from the servicing logic
//   calls       : registered calls (illegal bits forced to 0)
module call_channel #(
  parameter int                    N_FLOORS = 4,
  parameter logic [N_FLOORS-1:0]   LEGAL    = '1
) (
  input  logic                clk,
  input  logic                srst,
  input  logic [N_FLOORS-1:0] btn,
  input  logic [N_FLOORS-1:0] floor_en,
  input  logic [N_FLOORS-1:0] clr,
  output logic [N_FLOORS-1:0] calls
);

  logic [N_FLOORS-1:0] btn_q_reg;
  logic [N_FLOORS-1:0] calls_reg;
  logic [N_FLOORS-1:0] calls_next;
  logic [N_FLOORS-1:0] rise;
  // Low for the first edge after reset.
  // The history register is cleared by reset. A button held through reset
  // would otherwise look like a fresh press when reset is released.
  logic                armed_reg;

  assign rise = btn & ~btn_q_reg & {N_FLOORS{armed_reg}};

  // Set first, then mask with clear, enable and legality.
  // The masking makes clear win over set.
  assign calls_next = (calls_reg | (rise & floor_en)) & ~clr & floor_en & LEGAL;

  always_ff @(posedge clk) begin
    if (srst) begin
      btn_q_reg <= '0;
      calls_reg <= '0;
      armed_reg <= 1'b0;
    end else begin
      btn_q_reg <= btn;
      calls_reg <= calls_next;
      armed_reg <= 1'b1;
    end
  end

  assign calls = calls_reg;

endmodule

// File: rtl/call_register_bank.sv
// Car and hall call storage for N_FLOORS floors, plus direction-decision
// status for the elevator controller.
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   btn_car/up/dn    : level button inputs
//                      top-floor up and bottom-floor down are ignored
//   floor_en         : per-floor service enable
//   cur_floor        : car position
//   dir_up           : travel direction; selects which hall call is served
//   svc_valid        : car stopped with doors open at cur_floor
//   car/up/dn_calls  : registered call vectors
//   call_here        : any call at cur_floor
//   call_above       : any call at a floor above cur_floor
//   call_below       : any call at a floor below cur_floor
//   any_call         : any call stored at all
//   pending_cnt      : number of stored call bits
// When cur_floor is out of range:
//   - svc_valid is ignored;
//   - every stored call is reported as below.
module call_register_bank
  import call_register_bank_pkg::*;
#(
  parameter int N_FLOORS = 4,
  parameter int FW       = floor_w(N_FLOORS),
  parameter int CW       = count_w(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] btn_car,
  input  logic [N_FLOORS-1:0] btn_up,
  input  logic [N_FLOORS-1:0] btn_dn,
  input  logic [N_FLOORS-1:0] floor_en,
  input  logic [FW-1:0]       cur_floor,
  input  logic                dir_up,
  input  logic                svc_valid,
  output logic [N_FLOORS-1:0] car_calls,
  output logic [N_FLOORS-1:0] up_calls,
  output logic [N_FLOORS-1:0] dn_calls,
  output logic                call_here,
  output logic                call_above,
  output logic                call_below,
  output logic                any_call,
  output logic [CW-1:0]       pending_cnt
);

  localparam logic [N_FLOORS-1:0] LEGAL_CAR = '1;
  localparam logic [N_FLOORS-1:0] LEGAL_UP  = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] LEGAL_DN  = {{(N_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FW:0]         N_FLOORS_W = (FW+1)'(N_FLOORS);

  logic                in_range;
  logic                svc_ok;
  logic [N_FLOORS-1:0] floor_hit;
  logic [N_FLOORS-1:0] above_mask;
  logic [N_FLOORS-1:0] below_mask;
  logic [N_FLOORS-1:0] any_floor;
  logic [N_FLOORS-1:0] btn_ch   [N_CH];
  logic [N_FLOORS-1:0] clr_ch   [N_CH];
  logic [N_FLOORS-1:0] calls_ch [N_CH];
  logic [CW-1:0]       pending_sum;

  // Widen by one bit so N_FLOORS itself is representable in the compare.
  assign in_range = ({1'b0, cur_floor} < N_FLOORS_W);
  assign svc_ok   = svc_valid && in_range;

  genvar gi;
  generate
    for (gi = 0; gi < N_FLOORS; gi++) begin : g_floor
      assign floor_hit[gi]  = in_range && (cur_floor == FW'(gi));
      assign above_mask[gi] = in_range && (cur_floor <  FW'(gi));
      assign below_mask[gi] = !in_range || (cur_floor > FW'(gi));
    end
  endgenerate

  assign btn_ch[CH_CAR] = btn_car;
  assign btn_ch[CH_UP]  = btn_up;
  assign btn_ch[CH_DN]  = btn_dn;

  // Car calls are always cleared on service.
  // Only the hall call matching the travel direction is cleared.
  assign clr_ch[CH_CAR] = floor_hit & {N_FLOORS{svc_ok}};
  assign clr_ch[CH_UP]  = floor_hit & {N_FLOORS{svc_ok &&  dir_up}};
  assign clr_ch[CH_DN]  = floor_hit & {N_FLOORS{svc_ok && !dir_up}};

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      localparam logic [N_FLOORS-1:0] LEGAL =
        (gi == CH_UP) ? LEGAL_UP : ((gi == CH_DN) ? LEGAL_DN : LEGAL_CAR);
      call_channel #(
        .N_FLOORS (N_FLOORS),
        .LEGAL    (LEGAL)
      ) u_channel (
        .clk      (clk),
        .srst     (rst),
        .btn      (btn_ch[gi]),
        .floor_en (floor_en),
        .clr      (clr_ch[gi]),
        .calls    (calls_ch[gi])
      );
    end
  endgenerate

  assign car_calls = calls_ch[CH_CAR];
  assign up_calls  = calls_ch[CH_UP];
  assign dn_calls  = calls_ch[CH_DN];

  assign any_floor  = car_calls | up_calls | dn_calls;
  assign call_here  = |(any_floor & floor_hit);
  assign call_above = |(any_floor & above_mask);
  assign call_below = |(any_floor & below_mask);
  assign any_call   = |any_floor;

  always_comb begin
    pending_sum = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      pending_sum = pending_sum + CW'(car_calls[i]) + CW'(up_calls[i]) + CW'(dn_calls[i]);
    end
  end

  assign pending_cnt = pending_sum;

endmodule

// File: tb/tb_call_register_bank.sv
module tb_call_register_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-floor instance
  logic       rst;
  logic [3:0] btn_car, btn_up, btn_dn, floor_en;
  logic [1:0] cur_floor;
  logic       dir_up, svc_valid;
  logic [3:0] car_calls, up_calls, dn_calls;
  logic       call_here, call_above, call_below, any_call;
  logic [3:0] pending_cnt;

  // 5-floor instance (3-bit floor index allows out-of-range positions)
  logic       rst5;
  logic [4:0] btn_car5, btn_up5, btn_dn5, floor_en5;
  logic [2:0] cur_floor5;
  logic       dir_up5, svc_valid5;
  logic [4:0] car_calls5, up_calls5, dn_calls5;
  logic       call_here5, call_above5, call_below5, any_call5;
  logic [3:0] pending_cnt5;

  int n_vec = 0;
  int n_bad = 0;

  call_register_bank #(.N_FLOORS(4)) u_dut4 (
    .clk(clk), .rst(rst), .btn_car(btn_car), .btn_up(btn_up), .btn_dn(btn_dn),
    .floor_en(floor_en), .cur_floor(cur_floor), .dir_up(dir_up), .svc_valid(svc_valid),
    .car_calls(car_calls), .up_calls(up_calls), .dn_calls(dn_calls),
    .call_here(call_here), .call_above(call_above), .call_below(call_below),
    .any_call(any_call), .pending_cnt(pending_cnt)
  );

  call_register_bank #(.N_FLOORS(5)) u_dut5 (
    .clk(clk), .rst(rst5), .btn_car(btn_car5), .btn_up(btn_up5), .btn_dn(btn_dn5),
    .floor_en(floor_en5), .cur_floor(cur_floor5), .dir_up(dir_up5), .svc_valid(svc_valid5),
    .car_calls(car_calls5), .up_calls(up_calls5), .dn_calls(dn_calls5),
    .call_here(call_here5), .call_above(call_above5), .call_below(call_below5),
    .any_call(any_call5), .pending_cnt(pending_cnt5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_vec4(input string tag, input logic [3:0] car, input logic [3:0] up,
                          input logic [3:0] dn, input logic [3:0] cnt);
    chk({tag, " car"}, 32'(car_calls), 32'(car));
    chk({tag, " up"},  32'(up_calls),  32'(up));
    chk({tag, " dn"},  32'(dn_calls),  32'(dn));
    chk({tag, " cnt"}, 32'(pending_cnt), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; btn_car = 4'b0010; btn_up = '0; btn_dn = '0; floor_en = 4'hF;
    cur_floor = 2'd0; dir_up = 1'b1; svc_valid = 1'b0;
    rst5 = 1'b1; btn_car5 = '0; btn_up5 = '0; btn_dn5 = '0; floor_en5 = 5'h1F;
    cur_floor5 = 3'd0; dir_up5 = 1'b1; svc_valid5 = 1'b0;

    // Reset held two cycles with btn_car[1] held
    tick(2);
    chk_vec4("reset", 4'b0, 4'b0, 4'b0, 4'd0);
    chk("reset flags", 32'({call_here, call_above, call_below, any_call}), 32'(4'b0000));
    rst = 1'b0; rst5 = 1'b0;
    tick(2);
    chk("held through reset car", 32'(car_calls), 32'(4'b0000));
    btn_car = '0;
    tick();

    // Press latency and hold
    btn_car = 4'b0100;
    tick();
    chk_vec4("press", 4'b0100, 4'b0, 4'b0, 4'd1);
    chk("press above", 32'(call_above), 32'(1'b1));
    chk("press below", 32'(call_below), 32'(1'b0));
    chk("press here",  32'(call_here),  32'(1'b0));
    tick(9);
    chk_vec4("held", 4'b0100, 4'b0, 4'b0, 4'd1);
    btn_car = '0;
    cur_floor = 2'd2; svc_valid = 1'b1;
    tick();
    svc_valid = 1'b0;
    chk("service floor2 car", 32'(car_calls), 32'(4'b0000));

    // Directional clear
    btn_up = 4'b0010; btn_dn = 4'b0010;
    tick();
    btn_up = '0; btn_dn = '0;
    chk_vec4("hall set", 4'b0, 4'b0010, 4'b0010, 4'd2);
    chk("hall below", 32'(call_below), 32'(1'b1));
    cur_floor = 2'd1; dir_up = 1'b1; svc_valid = 1'b1;
    tick();
    svc_valid = 1'b0;
    chk_vec4("dir clear up", 4'b0, 4'b0000, 4'b0010, 4'd1);
    chk("dir clear here", 32'(call_here), 32'(1'b1));
    dir_up = 1'b0; svc_valid = 1'b1;
    tick();
    svc_valid = 1'b0; dir_up = 1'b1;
    chk_vec4("dir clear dn", 4'b0, 4'b0, 4'b0, 4'd0);

    // Simultaneous set and clear; clear wins
    cur_floor = 2'd3; svc_valid = 1'b1; btn_car = 4'b1000;
    tick();
    chk("set vs clear car", 32'(car_calls), 32'(4'b0000));
    svc_valid = 1'b0; btn_car = '0;
    tick();
    btn_car = 4'b1000;
    tick();
    chk("repress car", 32'(car_calls), 32'(4'b1000));
    chk("repress here", 32'(call_here), 32'(1'b1));
    svc_valid = 1'b1;
    tick();
    svc_valid = 1'b0;
    tick(2);
    chk("held after service car", 32'(car_calls), 32'(4'b0000));
    btn_car = '0;
    tick();

    // Illegal hall calls
    btn_up = 4'b1000; btn_dn = 4'b0001;
    tick();
    btn_up = '0; btn_dn = '0;
    tick();
    chk_vec4("illegal", 4'b0, 4'b0, 4'b0, 4'd0);
    chk("illegal any", 32'(any_call), 32'(1'b0));

    // floor_en drop
    cur_floor = 2'd0;
    btn_car = 4'b0101; btn_up = 4'b0100; btn_dn = 4'b0100;
    tick();
    btn_car = '0; btn_up = '0; btn_dn = '0;
    chk_vec4("fen set", 4'b0101, 4'b0100, 4'b0100, 4'd4);
    chk("fen here", 32'(call_here), 32'(1'b1));
    chk("fen above", 32'(call_above), 32'(1'b1));
    floor_en = 4'b1011;
    tick();
    chk_vec4("fen drop", 4'b0001, 4'b0, 4'b0, 4'd1);
    btn_car = 4'b0100;
    tick();
    chk("fen press ignored", 32'(car_calls), 32'(4'b0001));
    floor_en = 4'hF;
    tick();
    chk("fen reenable", 32'(car_calls), 32'(4'b0001));
    btn_car = '0;

    // Reset mid-operation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_vec4("mid reset", 4'b0, 4'b0, 4'b0, 4'd0);

    // Out-of-range position on the 5-floor instance
    btn_car5 = 5'b00100; btn_up5 = 5'b00010;
    tick();
    btn_car5 = '0; btn_up5 = '0;
    cur_floor5 = 3'd7; svc_valid5 = 1'b1; dir_up5 = 1'b1;
    tick();
    chk("oor car5", 32'(car_calls5), 32'(5'b00100));
    chk("oor up5", 32'(up_calls5), 32'(5'b00010));
    chk("oor cnt5", 32'(pending_cnt5), 32'(4'd2));
    chk("oor flags5", 32'({call_here5, call_above5, call_below5, any_call5}), 32'(4'b0011));
    cur_floor5 = 3'd5;
    tick();
    chk("oor5 flags5", 32'({call_here5, call_above5, call_below5, any_call5}), 32'(4'b0011));
    svc_valid5 = 1'b0; cur_floor5 = 3'd2;
    #1;
    chk("inrange flags5", 32'({call_here5, call_above5, call_below5, any_call5}), 32'(4'b1011));
    cur_floor5 = 3'd4;
    #1;
    chk("top flags5", 32'({call_here5, call_above5, call_below5, any_call5}), 32'(4'b0011));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
